// File: rtl/fir_out_reader.sv
// Capture side of the FIR datapath: decimated sampling of y into a FWFT FIFO with a
// valid/ready drain and a sticky overflow flag. Optional peak tracker: FIR_OUT_READER_PEAK_EN.
module fir_out_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DECIM = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           y_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
`ifdef FIR_OUT_READER_PEAK_EN
  ,
  output logic [WIDTH-1:0]           peak,
  input  logic                       clr_peak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DW-1:0]    dcnt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             cap, empty, full, push, pop, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cap  = en && (dcnt == '0);
  assign pop  = !empty && out_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (en) begin
      if (dcnt == DW'(DECIM - 1)) dcnt <= '0;
      else                        dcnt <= dcnt + DW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked by the
  // pointers and out_data is forced to zero while empty, so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop coinciding with clr_ovf leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef FIR_OUT_READER_PEAK_EN
  // Peak follows every capture, including ones the full FIFO drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (cap) begin
      if (clr_peak || (y_in > peak)) peak <= y_in;
    end else if (clr_peak) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_reader.sv
// Directed self-checking bench for fir_out_reader: DECIM=1 instance for FIFO behaviour,
// DECIM=3 instance for decimation phase; peak checks when FIR_OUT_READER_PEAK_EN is defined.
module tb_fir_out_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, out_ready, clr_ovf, out_valid, overflow;
  logic [7:0] y_in, out_data;
  logic [2:0] level;

  logic       en3, out_ready3, out_valid3, overflow3;
  logic [7:0] y3, out_data3;
  logic [2:0] level3;

`ifdef FIR_OUT_READER_PEAK_EN
  logic [7:0] peak, peak3;
  logic       clr_peak;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_out_reader #(.WIDTH(8), .DEPTH(4), .DECIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef FIR_OUT_READER_PEAK_EN
    , .peak(peak), .clr_peak(clr_peak)
`endif
  );

  fir_out_reader #(.WIDTH(8), .DEPTH(4), .DECIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .y_in(y3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .level(level3), .overflow(overflow3), .clr_ovf(1'b0)
`ifdef FIR_OUT_READER_PEAK_EN
    , .peak(peak3), .clr_peak(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_10_13();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_in = 8'h10 + 8'(i);
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; y_in = 8'hAA; out_ready = 1'b0; clr_ovf = 1'b0;
    en3 = 1'b0; y3 = 8'h00; out_ready3 = 1'b0;
`ifdef FIR_OUT_READER_PEAK_EN
    clr_peak = 1'b0;
`endif
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
`ifdef FIR_OUT_READER_PEAK_EN
    check("rst_peak", peak, 8'h00);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    check("first_valid", out_valid, 1);
    check("first_data", out_data, 8'hAA);
    check("first_level", level, 1);
    en = 1'b0; out_ready = 1'b1;
    step();
    check("first_drain", out_valid, 0);

    // Three captures then drain
    out_ready = 1'b0; en = 1'b1;
    y_in = 8'h01; step();
    y_in = 8'h02; step();
    y_in = 8'h03; step();
    en = 1'b0;
    check("three_level", level, 3);
    check("three_head", out_data, 8'h01);
    out_ready = 1'b1;
    step(); check("three_d2", out_data, 8'h02);
    step(); check("three_d3", out_data, 8'h03);
    step();
    check("three_empty_v", out_valid, 0);
    check("three_empty_l", level, 0);
    check("three_empty_d", out_data, 8'h00);
    step(); check("ready_on_empty", level, 0);

    // Overflow: 10..14 into a 4-deep FIFO
    fill_10_13();
    check("full_level", level, 4);
    check("full_no_ovf", overflow, 0);
    en = 1'b1; y_in = 8'h14; step(); en = 1'b0;
    check("ovf_level", level, 4);
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    check("ovf_d0", out_data, 8'h10);
    step(); check("ovf_d1", out_data, 8'h11);
    step(); check("ovf_d2", out_data, 8'h12);
    step(); check("ovf_d3", out_data, 8'h13);
    step(); check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full with simultaneous push and pop
    fill_10_13();
    en = 1'b1; y_in = 8'h20; out_ready = 1'b1; step(); en = 1'b0;
    check("pp_level", level, 4);
    check("pp_no_ovf", overflow, 0);
    check("pp_d0", out_data, 8'h11);
    step(); check("pp_d1", out_data, 8'h12);
    step(); check("pp_d2", out_data, 8'h13);
    step(); check("pp_d3", out_data, 8'h20);
    step(); check("pp_empty", out_valid, 0);

    // Drop coinciding with clr_ovf: set wins
    fill_10_13();
    en = 1'b1; y_in = 8'h55; clr_ovf = 1'b1; step(); en = 1'b0; clr_ovf = 1'b0;
    check("set_wins", overflow, 1);
    out_ready = 1'b1; step(); step(); step(); step();
    check("set_wins_drain", level, 0);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    // DECIM=3: 00..08 continuous
    en3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      y3 = 8'(i);
      step();
    end
    en3 = 1'b0;
    check("dec_level", level3, 3);
    out_ready3 = 1'b1;
    check("dec_d0", out_data3, 8'h00);
    step(); check("dec_d1", out_data3, 8'h03);
    step(); check("dec_d2", out_data3, 8'h06);
    step(); check("dec_empty", out_valid3, 0);
    out_ready3 = 1'b0;

    // DECIM=3 with a 2-cycle enable gap: captures 50 and 55
    en3 = 1'b1; y3 = 8'h50; step();
    y3 = 8'h51; step();
    en3 = 1'b0; y3 = 8'h52; step();
    y3 = 8'h53; step();
    en3 = 1'b1; y3 = 8'h54; step();
    y3 = 8'h55; step();
    en3 = 1'b0;
    check("gap_level", level3, 2);
    out_ready3 = 1'b1;
    check("gap_d0", out_data3, 8'h50);
    step(); check("gap_d1", out_data3, 8'h55);
    step(); check("gap_empty", out_valid3, 0);
    out_ready3 = 1'b0;

    // Asynchronous reset mid-operation discards data immediately
    out_ready = 1'b0; en = 1'b1;
    y_in = 8'h66; step();
    y_in = 8'h67; step();
    en = 1'b0;
    check("pre_rst_level", level, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_data", out_data, 8'h00);
    @(posedge clk); #1; rst_n = 1'b1;

`ifdef FIR_OUT_READER_PEAK_EN
    out_ready = 1'b1; en = 1'b1;
    y_in = 8'h05; step();
    y_in = 8'h7F; step();
    y_in = 8'h12; step();
    check("peak_max", peak, 8'h7F);
    y_in = 8'h30; clr_peak = 1'b1; step();
    check("peak_clr_cap", peak, 8'h30);
    en = 1'b0; step();
    check("peak_clr_nocap", peak, 8'h00);
    clr_peak = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_out_reader.md
Name: fir_out_reader

Overview:
Capture side of the FIR datapath. Samples the filter output y at a programmable decimation rate and buffers the samples in a small first-word-fall-through (FWFT) FIFO. Presents them to a downstream consumer (pin serializer or host port) over a valid/ready handshake. Flags lost samples with a sticky overflow bit.

Parameters:
WIDTH, 8, sample width; matches FIR output y.
DEPTH, 4, FIFO entries; power of two, minimum 2.
DECIM, 1, capture one of every DECIM enabled cycles; minimum 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  capture enable; decimation counter advances only when high.
y_in  input  WIDTH  FIR output sample.
out_data  output  WIDTH  FIFO head sample.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data this cycle.
level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
overflow  output  1  sticky; set when a capture is dropped.
clr_ovf  input  1  clears overflow.
peak  output  WIDTH  present only with the optional feature; otherwise absent.
clr_peak  input  1  present only with the optional feature; otherwise absent.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO flushed; read/write pointers and decimation counter cleared to 0.
  - out_valid=0, out_data=0, level=0, overflow=0, peak=0.
  - Asserting rst_n low mid-operation discards all stored data immediately.
- Decimation counter dcnt, range 0..DECIM-1:
  - en=1 and dcnt==DECIM-1: dcnt wraps to 0.
  - en=1 otherwise: dcnt increments.
  - en=0: dcnt holds.
  - Capture strobe cap = en & (dcnt==0). With DECIM=1, every enabled cycle captures.
- Push:
  - cap=1 writes y_in into the FIFO at the clock edge.
  - The sample is visible on out_data / out_valid in the next cycle.
  - Capture-to-output latency is 1 cycle when the FIFO was empty.
- Pop:
  - Occurs when out_valid & out_ready; the head advances at that edge.
  - out_ready while empty is ignored.
- out_data:
  - Equals the head entry whenever out_valid=1.
  - Is 0 when empty; no stale data is shown.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - When full, push is allowed only because a pop occurs in the same cycle; no overflow.
  - When empty, the pushed sample appears next cycle; the pop is ignored.
- Full (level==DEPTH), push without pop:
  - Sample dropped and FIFO unchanged.
  - overflow set at that edge.
- overflow:
  - Cleared by clr_ovf=1.
  - If a drop and clr_ovf coincide, overflow=1 (set wins).
- level: updated at the same edge as the push/pop; registered, not combinational.
- Pointers: log2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH; full/empty derived from the MSB compare.
- Order: strict FIFO; no reordering or duplication.

Optional Feature:
- Macro: FIR_OUT_READER_PEAK_EN.
- Defined:
  - peak register tracks the maximum unsigned captured value, updated on cap.
  - clr_peak=1 loads the current capture value if cap=1, else loads 0.
  - Dropped (overflow) samples still update peak.
- Undefined: peak and clr_peak ports and all peak logic are removed; remaining behaviour is identical.

Test Plan:
- Reset with y_in=AA, en=1 -> out_valid=0, out_data=00, level=0, overflow=0; after rst_n release, the first capture of AA appears next cycle.
- DEPTH=4, DECIM=1, out_ready=0, en=1 for 3 cycles, y_in=01,02,03 -> level=3, out_data=01. Then en=0, out_ready=1 -> out_data 01,02,03 on successive cycles, then out_valid=0, level=0.
- out_ready=0, capture 10,11,12,13,14 -> level=4, overflow=1. Drain yields 10,11,12,13 only. clr_ovf pulse -> overflow=0.
- Full FIFO (10..13), push 20 with out_ready=1 in the same cycle -> level stays 4, overflow=0, drain order 11,12,13,20.
- DECIM=3, en=1 continuous, y_in=00..08 one per cycle -> FIFO receives 00,03,06. Drop en for 2 cycles mid-stream -> dcnt holds and the capture phase shifts by 2.
- PEAK_EN defined, captures 05,7F,12 -> peak=7F. clr_peak coinciding with capture 30 -> peak=30. clr_peak with no capture -> peak=00.
